mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared widths, starvation limit and arbiter state encoding for the instruction/data memory arbiter.
package params_pkg;

  localparam int ADDR_WIDTH   = 32;
  localparam int DATA_WIDTH   = 32;
  localparam int STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_INSTR = 2'd1,
    WAIT_DATA  = 2'd2,
    WAIT_DROP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU fetch/data ports, the arbiter and the single-ported memory.
interface mem_arbiter_if;
  import params_pkg::*;

  logic                  if_req_valid_i;
  logic [ADDR_WIDTH-1:0] if_req_addr_i;
  logic                  if_flush_i;
  logic                  if_req_ready_o;
  logic                  if_rsp_valid_o;
  logic [DATA_WIDTH-1:0] if_rsp_data_o;

  logic                  d_req_valid_i;
  logic                  d_req_we_i;
  logic [ADDR_WIDTH-1:0] d_req_addr_i;
  logic [DATA_WIDTH-1:0] d_req_wdata_i;
  logic                  d_req_ready_o;
  logic                  d_rsp_valid_o;
  logic [DATA_WIDTH-1:0] d_rsp_data_o;

  logic                  mem_rd_req_valid_o;
  logic                  mem_wr_req_valid_o;
  logic                  mem_req_is_instr_o;
  logic [ADDR_WIDTH-1:0] mem_req_address_o;
  logic [DATA_WIDTH-1:0] mem_wr_data_o;
  logic                  mem_data_valid_i;
  logic                  mem_data_is_instr_i;
  logic [DATA_WIDTH-1:0] mem_data_i;

  logic                  err_o;

  modport slave (
    input  if_req_valid_i, if_req_addr_i, if_flush_i,
    output if_req_ready_o, if_rsp_valid_o, if_rsp_data_o,
    input  d_req_valid_i, d_req_we_i, d_req_addr_i, d_req_wdata_i,
    output d_req_ready_o, d_rsp_valid_o, d_rsp_data_o,
    output mem_rd_req_valid_o, mem_wr_req_valid_o, mem_req_is_instr_o,
    output mem_req_address_o, mem_wr_data_o,
    input  mem_data_valid_i, mem_data_is_instr_i, mem_data_i,
    output err_o
  );

  modport master (
    output if_req_valid_i, if_req_addr_i, if_flush_i,
    input  if_req_ready_o, if_rsp_valid_o, if_rsp_data_o,
    output d_req_valid_i, d_req_we_i, d_req_addr_i, d_req_wdata_i,
    input  d_req_ready_o, d_rsp_valid_o, d_rsp_data_o,
    input  mem_rd_req_valid_o, mem_wr_req_valid_o, mem_req_is_instr_o,
    input  mem_req_address_o, mem_wr_data_o,
    output mem_data_valid_i, mem_data_is_instr_i, mem_data_i,
    input  err_o
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one memory port with a single outstanding
// request, data priority bounded by a starvation counter, and flush-driven fetch discard.
module mem_arbiter (
  input  logic          clk_i,
  input  logic          rst_i,
  mem_arbiter_if.slave  bus
);
  import params_pkg::*;

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_t            r_state;
  arb_state_t            w_next_state;
  logic [STARVE_W-1:0]   r_starve_cnt;
  logic                  r_err;
  logic                  r_mem_rd;
  logic                  r_mem_wr;
  logic                  r_is_instr;
  logic                  r_is_store;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_if_rsp_valid;
  logic [DATA_WIDTH-1:0] r_if_rsp_data;
  logic                  r_d_rsp_valid;
  logic [DATA_WIDTH-1:0] r_d_rsp_data;

  logic w_fetch_req;
  logic w_rsp_instr;
  logic w_rsp_data;
  logic w_grant_if;
  logic w_grant_d;
  logic w_if_done;
  logic w_d_done;
  logic w_err;

  // A fetch that is being redirected this cycle is not a candidate for a grant
  assign w_fetch_req = bus.if_req_valid_i & ~bus.if_flush_i;
  assign w_rsp_instr = bus.mem_data_valid_i &  bus.mem_data_is_instr_i;
  assign w_rsp_data  = bus.mem_data_valid_i & ~bus.mem_data_is_instr_i;

  always_comb begin
    w_next_state = r_state;
    w_grant_if   = 1'b0;
    w_grant_d    = 1'b0;
    w_if_done    = 1'b0;
    w_d_done     = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      IDLE: begin
        w_err = bus.mem_data_valid_i;
        // Grants are held off while reset is asserted so ready outputs read 0
        if (rst_i) begin
          if (bus.d_req_valid_i && !(w_fetch_req && (r_starve_cnt == STARVE_MAX))) begin
            w_grant_d    = 1'b1;
            w_next_state = WAIT_DATA;
          end else if (w_fetch_req) begin
            w_grant_if   = 1'b1;
            w_next_state = WAIT_INSTR;
          end
        end
      end
      WAIT_INSTR: begin
        if (w_rsp_instr) begin
          w_if_done    = ~bus.if_flush_i;
          w_next_state = IDLE;
        end else begin
          w_err = w_rsp_data;
          if (bus.if_flush_i) w_next_state = WAIT_DROP;
        end
      end
      WAIT_DATA: begin
        if (w_rsp_data) begin
          w_d_done     = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_err = w_rsp_instr;
        end
      end
      WAIT_DROP: begin
        if (w_rsp_instr) w_next_state = IDLE;
        else             w_err = w_rsp_data;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_grant_if) begin
        r_starve_cnt <= '0;
      end else if (w_grant_d && w_fetch_req && (r_starve_cnt != STARVE_MAX)) begin
        r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
      end
      if (w_err) r_err <= 1'b1;
    end
  end

  // Memory command is a one-cycle pulse; address/data hold their last captured value
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_is_instr  <= 1'b0;
      r_is_store  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_rd   <= w_grant_if | (w_grant_d & ~bus.d_req_we_i);
      r_mem_wr   <= w_grant_d & bus.d_req_we_i;
      r_is_instr <= w_grant_if;
      if (w_grant_if) begin
        r_mem_addr <= bus.if_req_addr_i;
      end else if (w_grant_d) begin
        r_mem_addr  <= bus.d_req_addr_i;
        r_mem_wdata <= bus.d_req_we_i ? bus.d_req_wdata_i : '0;
        r_is_store  <= bus.d_req_we_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_if_rsp_valid <= 1'b0;
      r_if_rsp_data  <= '0;
      r_d_rsp_valid  <= 1'b0;
      r_d_rsp_data   <= '0;
    end else begin
      r_if_rsp_valid <= w_if_done;
      r_d_rsp_valid  <= w_d_done;
      if (w_if_done) r_if_rsp_data <= bus.mem_data_i;
      if (w_d_done)  r_d_rsp_data  <= r_is_store ? '0 : bus.mem_data_i;
    end
  end

  assign bus.if_req_ready_o     = w_grant_if;
  assign bus.d_req_ready_o      = w_grant_d;
  assign bus.if_rsp_valid_o     = r_if_rsp_valid;
  assign bus.if_rsp_data_o      = r_if_rsp_data;
  assign bus.d_rsp_valid_o      = r_d_rsp_valid;
  assign bus.d_rsp_data_o       = r_d_rsp_data;
  assign bus.mem_rd_req_valid_o = r_mem_rd;
  assign bus.mem_wr_req_valid_o = r_mem_wr;
  assign bus.mem_req_is_instr_o = r_is_instr;
  assign bus.mem_req_address_o  = r_mem_addr;
  assign bus.mem_wr_data_o      = r_mem_wdata;
  assign bus.err_o              = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch-only, priority, starvation, flush, error and reset scenarios.
module tb_mem_arbiter;
  import params_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  mem_arbiter_if bus();

  mem_arbiter dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic driveFetch(input logic v, input logic [ADDR_WIDTH-1:0] a, input logic fl);
    bus.if_req_valid_i = v;
    bus.if_req_addr_i  = a;
    bus.if_flush_i     = fl;
  endtask

  task automatic driveData(input logic v, input logic we, input logic [ADDR_WIDTH-1:0] a,
                           input logic [DATA_WIDTH-1:0] d);
    bus.d_req_valid_i = v;
    bus.d_req_we_i    = we;
    bus.d_req_addr_i  = a;
    bus.d_req_wdata_i = d;
  endtask

  task automatic driveMem(input logic v, input logic instr, input logic [DATA_WIDTH-1:0] d);
    bus.mem_data_valid_i    = v;
    bus.mem_data_is_instr_i = instr;
    bus.mem_data_i          = d;
  endtask

  task automatic applyStimulus();
    driveFetch(1'b0, '0, 1'b0);
    driveData(1'b0, 1'b0, '0, '0);
    driveMem(1'b0, 1'b0, '0);
  endtask

  initial begin
    applyStimulus();
    #1;
    checkOutput("rst_state",  64'(dut.r_state), 64'(IDLE));
    checkOutput("rst_err",    64'(bus.err_o), 64'd0);
    checkOutput("rst_memrd",  64'(bus.mem_rd_req_valid_o), 64'd0);
    checkOutput("rst_addr",   64'(bus.mem_req_address_o), 64'd0);
    checkOutput("rst_ifrsp",  64'(bus.if_rsp_valid_o), 64'd0);
    nextCycle();
    nextCycle();
    rst_i = 1'b1;
    nextCycle();

    // Fetch-only transaction with a 3-cycle response
    driveFetch(1'b1, 32'h10, 1'b0);
    #1;
    checkOutput("f_ifready", 64'(bus.if_req_ready_o), 64'd1);
    checkOutput("f_dready",  64'(bus.d_req_ready_o), 64'd0);
    nextCycle();
    driveFetch(1'b0, '0, 1'b0);
    checkOutput("f_memrd",   64'(bus.mem_rd_req_valid_o), 64'd1);
    checkOutput("f_isinstr", 64'(bus.mem_req_is_instr_o), 64'd1);
    checkOutput("f_memwr",   64'(bus.mem_wr_req_valid_o), 64'd0);
    checkOutput("f_addr",    64'(bus.mem_req_address_o), 64'h10);
    nextCycle();
    checkOutput("f_memrd_off", 64'(bus.mem_rd_req_valid_o), 64'd0);
    checkOutput("f_state",     64'(dut.r_state), 64'(WAIT_INSTR));
    nextCycle();
    driveMem(1'b1, 1'b1, 32'hDEADBEEF);
    nextCycle();
    driveMem(1'b0, 1'b0, '0);
    checkOutput("f_rspv",  64'(bus.if_rsp_valid_o), 64'd1);
    checkOutput("f_rspd",  64'(bus.if_rsp_data_o), 64'hDEADBEEF);
    checkOutput("f_idle",  64'(dut.r_state), 64'(IDLE));
    nextCycle();
    checkOutput("f_rspv_off", 64'(bus.if_rsp_valid_o), 64'd0);
    checkOutput("f_err",      64'(bus.err_o), 64'd0);

    // Simultaneous fetch and store: store first, fetch in the response-pulse cycle
    driveFetch(1'b1, 32'h20, 1'b0);
    driveData(1'b1, 1'b1, 32'h100, 32'h55);
    #1;
    checkOutput("p_dready",  64'(bus.d_req_ready_o), 64'd1);
    checkOutput("p_ifready", 64'(bus.if_req_ready_o), 64'd0);
    nextCycle();
    driveData(1'b0, 1'b0, '0, '0);
    #1;
    checkOutput("p_memwr",   64'(bus.mem_wr_req_valid_o), 64'd1);
    checkOutput("p_memrd",   64'(bus.mem_rd_req_valid_o), 64'd0);
    checkOutput("p_addr",    64'(bus.mem_req_address_o), 64'h100);
    checkOutput("p_wdata",   64'(bus.mem_wr_data_o), 64'h55);
    checkOutput("p_ifready_busy", 64'(bus.if_req_ready_o), 64'd0);
    checkOutput("p_starve",  64'(dut.r_starve_cnt), 64'd1);
    nextCycle();
    driveMem(1'b1, 1'b0, 32'h99);
    nextCycle();
    driveMem(1'b0, 1'b0, '0);
    #1;
    checkOutput("p_drspv",   64'(bus.d_rsp_valid_o), 64'd1);
    checkOutput("p_drspd",   64'(bus.d_rsp_data_o), 64'd0);
    checkOutput("p_ifgrant", 64'(bus.if_req_ready_o), 64'd1);
    nextCycle();
    driveFetch(1'b0, '0, 1'b0);
    checkOutput("p_faddr",   64'(bus.mem_req_address_o), 64'h20);
    checkOutput("p_finstr",  64'(bus.mem_req_is_instr_o), 64'd1);
    checkOutput("p_starve0", 64'(dut.r_starve_cnt), 64'd0);
    driveMem(1'b1, 1'b1, 32'hCAFE);
    nextCycle();
    driveMem(1'b0, 1'b0, '0);
    checkOutput("p_frspd", 64'(bus.if_rsp_data_o), 64'hCAFE);

    // Continuous loads with a pending fetch: four data grants, then the fetch
    driveFetch(1'b1, 32'h44, 1'b0);
    driveData(1'b1, 1'b0, 32'h200, '0);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput($sformatf("s_dgrant%0d", k), 64'(bus.d_req_ready_o), 64'd1);
      checkOutput($sformatf("s_fwait%0d", k), 64'(bus.if_req_ready_o), 64'd0);
      nextCycle();
      driveMem(1'b1, 1'b0, 32'h1000 + 32'(k));
      nextCycle();
      driveMem(1'b0, 1'b0, '0);
      checkOutput($sformatf("s_ldata%0d", k), 64'(bus.d_rsp_data_o), 64'h1000 + 64'(k));
    end
    #1;
    checkOutput("s_cnt4",    64'(dut.r_starve_cnt), 64'd4);
    checkOutput("s_fgrant",  64'(bus.if_req_ready_o), 64'd1);
    checkOutput("s_dblock",  64'(bus.d_req_ready_o), 64'd0);
    nextCycle();
    applyStimulus();
    checkOutput("s_cnt0",    64'(dut.r_starve_cnt), 64'd0);
    checkOutput("s_faddr",   64'(bus.mem_req_address_o), 64'h44);
    driveMem(1'b1, 1'b1, 32'h4444);
    nextCycle();
    driveMem(1'b0, 1'b0, '0);
    checkOutput("s_frspv", 64'(bus.if_rsp_valid_o), 64'd1);

    // Flush in the command cycle discards the fetch response
    driveFetch(1'b1, 32'h40, 1'b0);
    nextCycle();
    driveFetch(1'b0, '0, 1'b1);
    nextCycle();
    driveFetch(1'b0, '0, 1'b0);
    checkOutput("fl_drop", 64'(dut.r_state), 64'(WAIT_DROP));
    nextCycle();
    driveMem(1'b1, 1'b1, 32'h1234);
    nextCycle();
    driveMem(1'b0, 1'b0, '0);
    checkOutput("fl_rspv", 64'(bus.if_rsp_valid_o), 64'd0);
    checkOutput("fl_idle", 64'(dut.r_state), 64'(IDLE));
    checkOutput("fl_err",  64'(bus.err_o), 64'd0);

    // Flush coinciding with the instruction response; then a flushed request is not granted
    driveFetch(1'b1, 32'h50, 1'b0);
    nextCycle();
    driveFetch(1'b0, '0, 1'b0);
    nextCycle();
    driveFetch(1'b0, '0, 1'b1);
    driveMem(1'b1, 1'b1, 32'h5555);
    nextCycle();
    driveMem(1'b0, 1'b0, '0);
    driveFetch(1'b1, 32'h60, 1'b1);
    #1;
    checkOutput("fs_rspv",   64'(bus.if_rsp_valid_o), 64'd0);
    checkOutput("fs_idle",   64'(dut.r_state), 64'(IDLE));
    checkOutput("fs_nogrant", 64'(bus.if_req_ready_o), 64'd0);
    nextCycle();
    applyStimulus();
    checkOutput("fs_memrd", 64'(bus.mem_rd_req_valid_o), 64'd0);

    // Wrong-type response while waiting for data sets a sticky error
    driveData(1'b1, 1'b0, 32'h300, '0);
    nextCycle();
    driveData(1'b0, 1'b0, '0, '0);
    driveMem(1'b1, 1'b1, 32'h77);
    nextCycle();
    driveMem(1'b1, 1'b0, 32'h88);
    checkOutput("e_err",   64'(bus.err_o), 64'd1);
    checkOutput("e_state", 64'(dut.r_state), 64'(WAIT_DATA));
    checkOutput("e_drspv", 64'(bus.d_rsp_valid_o), 64'd0);
    nextCycle();
    driveMem(1'b0, 1'b0, '0);
    checkOutput("e_drspd",  64'(bus.d_rsp_data_o), 64'h88);
    checkOutput("e_sticky", 64'(bus.err_o), 64'd1);
    nextCycle();

    // Reset in WAIT_DATA abandons the store; a late response then flags an error
    driveData(1'b1, 1'b1, 32'h400, 32'hABCD);
    nextCycle();
    nextCycle();
    checkOutput("r_waitd", 64'(dut.r_state), 64'(WAIT_DATA));
    rst_i = 1'b0;
    #1;
    checkOutput("r_state",  64'(dut.r_state), 64'(IDLE));
    checkOutput("r_err",    64'(bus.err_o), 64'd0);
    checkOutput("r_memwr",  64'(bus.mem_wr_req_valid_o), 64'd0);
    checkOutput("r_addr",   64'(bus.mem_req_address_o), 64'd0);
    checkOutput("r_wdata",  64'(bus.mem_wr_data_o), 64'd0);
    checkOutput("r_dready", 64'(bus.d_req_ready_o), 64'd0);
    nextCycle();
    applyStimulus();
    rst_i = 1'b1;
    nextCycle();
    driveMem(1'b1, 1'b0, 32'h9);
    nextCycle();
    driveMem(1'b0, 1'b0, '0);
    checkOutput("r_lateerr", 64'(bus.err_o), 64'd1);
    checkOutput("r_drspv",   64'(bus.d_rsp_valid_o), 64'd0);
    nextCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
